// File: rtl/adc_ctrl_pkg.sv
// Shared timing constants and slot-window helper for the ADC serial capture controller.
// Defining ADC_CTRL_I2S_DELAY_EN selects the I2S one-bit-delay slot window instead of left-justified.
package adc_ctrl_pkg;

  localparam int unsigned TIMING_W  = 11;
  localparam int unsigned SAMPLE_W  = 16;
  localparam logic [10:0] FE_VAL    = 11'h3FF;
  localparam logic [4:0]  CAP_PHASE = 5'h0F;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } pair_t;

  localparam pair_t PAIR_ZERO = '{l: 16'h0000, r: 16'h0000};

  // True when slot bit k carries sample data in the selected serial format.
  function automatic logic slot_active(input logic [4:0] k);
`ifdef ADC_CTRL_I2S_DELAY_EN
    slot_active = (k >= 5'd1) && (k <= 5'd16);
`else
    slot_active = (k <= 5'd15);
`endif
  endfunction

endpackage

// File: rtl/adc_shift16.sv
// Per-channel serial-to-parallel capture: shifts din into the LSB on each enable, MSB arriving first.
module adc_shift16
  import adc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                din,
  output logic [SAMPLE_W-1:0] q
);

  logic [SAMPLE_W-1:0] sr_q;
  logic [SAMPLE_W-1:0] sr_d;

  // Next shift-register value
  always_comb begin
    if (en) begin
      sr_d = {sr_q[SAMPLE_W-2:0], din};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift-register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= 16'h0000;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/adc_ctrl.sv
// Stereo ADC serial interface controller: generates mclk/sclk/lrck, captures both channels, hands out pairs.
// Serial format is left-justified by default; ADC_CTRL_I2S_DELAY_EN selects I2S one-bit delay.
module adc_ctrl
  import adc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                sdto,
  input  logic                ack,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                valid,
  output logic                overrun
);

  logic [TIMING_W-1:0] timing_q;
  logic [TIMING_W-1:0] timing_d;
  logic                cap_s;
  logic                fe_s;
  logic [4:0]          k_s;
  logic                ch_s;
  logic                slot_en_s;
  logic                en_l_s;
  logic                en_r_s;
  logic [SAMPLE_W-1:0] sh_l_s;
  logic [SAMPLE_W-1:0] sh_r_s;
  pair_t               samples_q;
  pair_t               samples_d;
  logic                valid_q;
  logic                valid_d;
  logic                overrun_q;
  logic                overrun_d;
  logic                primed_q;
  logic                primed_d;

  // Free-running timebase; wraps naturally at its width
  always_comb begin
    timing_d = timing_q + 11'd1;
  end

  // Decode capture strobe, frame end and the slot/channel being received
  always_comb begin
    cap_s     = (timing_q[4:0] == CAP_PHASE);
    fe_s      = (timing_q == FE_VAL);
    k_s       = timing_q[9:5];
    ch_s      = timing_q[10];
    slot_en_s = cap_s & slot_active(k_s);
    en_l_s    = slot_en_s & ch_s;
    en_r_s    = slot_en_s & ~ch_s;
  end

  adc_shift16 u_shift_l (
    .clk   (clk),
    .reset (reset),
    .en    (en_l_s),
    .din   (sdto),
    .q     (sh_l_s)
  );

  adc_shift16 u_shift_r (
    .clk   (clk),
    .reset (reset),
    .en    (en_r_s),
    .din   (sdto),
    .q     (sh_r_s)
  );

  // Hand-off: the first frame end after reset only arms capture, later ones publish a pair
  always_comb begin
    samples_d = samples_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    primed_d  = primed_q;
    if (fe_s) begin
      primed_d = 1'b1;
      if (primed_q) begin
        samples_d = '{l: sh_l_s, r: sh_r_s};
        valid_d   = 1'b1;
        // An ack landing on the frame end consumes the old pair, so it is not an overrun
        if (valid_q && !ack) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end else begin
        samples_d = samples_q;
      end
    end else if (ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      valid_d   = valid_q;
    end
  end

  // Controller state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timing_q  <= 11'h000;
      samples_q <= PAIR_ZERO;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      primed_q  <= 1'b0;
    end else begin
      timing_q  <= timing_d;
      samples_q <= samples_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      primed_q  <= primed_d;
    end
  end

  assign mclk     = timing_q[2];
  assign sclk     = timing_q[4];
  assign lrck     = timing_q[10];
  assign sample_l = samples_q.l;
  assign sample_r = samples_q.r;
  assign valid    = valid_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/adc_ctrl.md
ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: sdto  input  1  serial data from ADC, MSB first.
REQ-004 SHALL have port: ack  input  1  consumer acknowledge of current sample pair.
REQ-005 SHALL have port: mclk  output  1  ADC master clock.
REQ-006 SHALL have port: sclk  output  1  serial bit clock.
REQ-007 SHALL have port: lrck  output  1  channel select; 1 = left, 0 = right.
REQ-008 SHALL have port: sample_l  output  16  last complete left sample, two's complement.
REQ-009 SHALL have port: sample_r  output  16  last complete right sample, two's complement.
REQ-010 SHALL have port: valid  output  1  level, new pair held in sample_l/sample_r.
REQ-011 SHALL have port: overrun  output  1  level, a pair was overwritten before ack.

Function
REQ-012 SHALL keep an 11-bit free-running counter timing, +1 per clk, wrapping 11'h7FF -> 11'h000.
REQ-013 SHALL drive mclk = timing[2], sclk = timing[4], lrck = timing[10] (periods 8, 32, 2048 clk).
REQ-014 SHALL define capture strobe cap = (timing[4:0] == 5'h0F), the last cycle of sclk low; sdto sampled on that clk edge.
REQ-015 SHALL use slot bit index k = timing[9:5] (0..31) and channel = timing[10].
REQ-016 SHALL, on cap with k in the active window (REQ-029), shift sdto into the channel's 16-bit shift register LSB, MSB first; other slot bits ignored.
REQ-017 SHALL define frame end fe = (timing == 11'h3FF); a frame is left half (400..7FF) then right half (000..3FF).
REQ-018 SHALL, on fe when primed, copy both shift registers to sample_l/sample_r and set valid to 1.
REQ-019 SHALL suppress the first fe after reset (partial frame), set primed, and leave outputs unchanged.
REQ-020 SHALL clear valid on the cycle after ack=1 when no fe occurs in that cycle; ack with valid=0 has no effect.
REQ-021 SHALL, on primed fe with valid=1 and ack=0, overwrite samples, keep valid=1, set overrun=1.
REQ-022 SHALL, on primed fe with valid=1 and ack=1, overwrite samples, keep valid=1, leave overrun unchanged.
REQ-023 SHALL clear overrun on ack=1 unless REQ-021 sets it in the same cycle.
REQ-024 SHALL keep sample_l/sample_r stable between fe updates.

Reset
REQ-025 SHALL, while reset=0, force timing=0, shift registers=0, primed=0.
REQ-026 SHALL, while reset=0, force sample_l=0, sample_r=0, valid=0, overrun=0, so mclk=sclk=lrck=0.
REQ-027 SHALL discard any partial frame on reset assertion mid-frame; first valid is at the second fe after release (timing 11'h3FF + 2048 cycles).

Configuration
REQ-028 SHALL select format by macro ADC_CTRL_I2S_DELAY_EN.
REQ-029 SHALL, without the macro, use left-justified format: active window k = 0..15, bit k -> sample bit 15-k; with the macro defined, use I2S one-bit delay: window k = 1..16, bit k -> sample bit 16-k.

Structure
REQ-030 SHALL place timing constants (counter width 11, FE value 11'h3FF, CAP phase 5'h0F, sample width 16) in shared package adc_ctrl_pkg.
REQ-031 SHALL implement per-channel serial-to-parallel capture as sub-module adc_shift16 (clk, reset, en, din, q[15:0]), instantiated twice.

Verification
REQ-032 SHALL cover: release reset, ADC model sends L=16'hA5C3, R=16'h5A3C every frame -> first valid at cycle 3071 after release (counting from timing=0), sample_l=A5C3, sample_r=5A3C.
REQ-033 SHALL cover: clock check -> mclk period 8, sclk period 32, lrck period 2048, lrck rises at timing 11'h400.
REQ-034 SHALL cover: no ack across two frames with L=16'h0001 then 16'h8000 -> sample_l=8000, valid=1, overrun=1; ack -> valid=0, overrun=0 next cycle.
REQ-035 SHALL cover: ack asserted exactly at timing 11'h3FF with valid=1 -> new samples loaded, valid=1, overrun=0.
REQ-036 SHALL cover: reset pulsed at timing 11'h600 -> all outputs 0 immediately, no valid until second fe after release.
REQ-037 SHALL cover: build with ADC_CTRL_I2S_DELAY_EN, model shifted one bit, L=16'hFFFE, R=16'h7FFF -> samples match; same stimulus without macro yields mismatch.
